// File: rtl/ysyx_23060180_mem_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060180_mem_pkg
//   Shared definitions for the core memory bridge and its alignment helper:
//   access size encoding, AXI response codes, the bridge state enum and a
//   helper that decides whether an access is misaligned.
// ----------------------------------------------------------------------------
package ysyx_23060180_mem_pkg;

    // Core request size encoding (req_size); 2'd3 is reserved
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WREQ,
        WRESP,
        RESP
    } bridge_state_t;

    // The reserved size is treated as misaligned so it never reaches the bus
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return addr_lo[0];
            SIZE_W:  return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060180_mem_bridge_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060180_mem_bridge_if
//   AXI4-Lite subset bus between the memory bridge (master) and a memory
//   slave. Channels: AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/
//   rready), AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//   B (bresp/bvalid/bready).
//   Modports: master (the bridge), slave (memory model / interconnect).
// ----------------------------------------------------------------------------
interface ysyx_23060180_mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/ysyx_23060180_mem_align.sv
// ----------------------------------------------------------------------------
// ysyx_23060180_mem_align
//   Purely combinational byte-lane helper for 32-bit word memory.
//   Ports:
//     addr_lo     in  2  : byte offset within the word
//     size        in  2  : access size (SIZE_B / SIZE_H / SIZE_W)
//     store_data  in  32 : right-justified store data
//     bus_rdata   in  32 : raw word read from the bus
//     misaligned  out 1  : access crosses its natural alignment
//     strb        out 4  : byte strobes for the store
//     store_lanes out 32 : store data shifted into its byte lanes
//     load_data   out 32 : read data shifted down to bit 0, upper bits zero
// ----------------------------------------------------------------------------
module ysyx_23060180_mem_align
    import ysyx_23060180_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    output logic        misaligned,
    output logic [3:0]  strb,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [3:0]  base_strb;
    logic [31:0] size_mask;
    logic [31:0] shifted_rdata;

    always_comb begin
        base_strb = 4'b0000;
        size_mask = 32'h0000_0000;
        case (size)
            SIZE_B: begin
                base_strb = 4'b0001;
                size_mask = 32'h0000_00FF;
            end
            SIZE_H: begin
                base_strb = 4'b0011;
                size_mask = 32'h0000_FFFF;
            end
            SIZE_W: begin
                base_strb = 4'b1111;
                size_mask = 32'hFFFF_FFFF;
            end
            default: begin
                base_strb = 4'b0000;
                size_mask = 32'h0000_0000;
            end
        endcase

        misaligned    = is_misaligned(size, addr_lo);
        strb          = base_strb << addr_lo;
        store_lanes   = store_data << {addr_lo, 3'b000};
        shifted_rdata = bus_rdata >> {addr_lo, 3'b000};
        load_data     = shifted_rdata & size_mask;
    end

endmodule

// File: rtl/ysyx_23060180_mem_bridge.sv
// ----------------------------------------------------------------------------
// ysyx_23060180_mem_bridge
//   Converts single core memory requests (valid/ready) into AXI4-Lite subset
//   transactions, one at a time, and returns a one-cycle completion pulse.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     req_valid/req_ready   : core request handshake
//     req_wen, req_size,
//     req_addr, req_wdata   : request attributes (store data right-justified)
//     rsp_valid, rsp_err,
//     rsp_rdata             : completion pulse, error flag, right-justified load
//     bus                   : AXI4-Lite subset master port
// ----------------------------------------------------------------------------
module ysyx_23060180_mem_bridge
    import ysyx_23060180_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wen,
    input  logic [1:0]                 req_size,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,

    output logic                       rsp_valid,
    output logic                       rsp_err,
    output logic [DATA_W-1:0]          rsp_rdata,

    ysyx_23060180_mem_bridge_if.master bus
);

    bridge_state_t state;
    logic [1:0]    addr_lo_q;
    logic [1:0]    size_q;

    logic [1:0]    align_addr_lo;
    logic [1:0]    align_size;
    logic          misaligned;
    logic [3:0]    strb;
    logic [31:0]   store_lanes;
    logic [31:0]   load_data;

    logic          aw_ok;
    logic          w_ok;

    // Reset also blocks acceptance so nothing slips in during the reset cycle
    assign req_ready = (state == IDLE) && !rst;

    // The aligner serves the incoming request while idle and the latched
    // request afterwards, so one instance covers both store and load paths
    assign align_addr_lo = (state == IDLE) ? req_addr[1:0] : addr_lo_q;
    assign align_size    = (state == IDLE) ? req_size      : size_q;

    ysyx_23060180_mem_align u_align (
        .addr_lo     (align_addr_lo),
        .size        (align_size),
        .store_data  (req_wdata),
        .bus_rdata   (bus.rdata),
        .misaligned  (misaligned),
        .strb        (strb),
        .store_lanes (store_lanes),
        .load_data   (load_data)
    );

    // A channel is finished once its valid has dropped or it handshakes now
    assign aw_ok = !bus.awvalid || bus.awready;
    assign w_ok  = !bus.wvalid  || bus.wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_lo_q   <= 2'b00;
            size_q      <= 2'b00;
            bus.araddr  <= '0;
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b0;
            bus.awaddr  <= '0;
            bus.awvalid <= 1'b0;
            bus.wdata   <= '0;
            bus.wstrb   <= '0;
            bus.wvalid  <= 1'b0;
            bus.bready  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_lo_q <= req_addr[1:0];
                        size_q    <= req_size;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        if (misaligned) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            state     <= RESP;
                        end else if (req_wen) begin
                            bus.awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            bus.awvalid <= 1'b1;
                            bus.wdata   <= store_lanes;
                            bus.wstrb   <= strb;
                            bus.wvalid  <= 1'b1;
                            state       <= WREQ;
                        end else begin
                            bus.araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            bus.arvalid <= 1'b1;
                            state       <= RADDR;
                        end
                    end
                end
                RADDR: begin
                    if (bus.arready) begin
                        bus.arvalid <= 1'b0;
                        bus.rready  <= 1'b1;
                        state       <= RDATA;
                    end
                end
                RDATA: begin
                    if (bus.rvalid) begin
                        bus.rready <= 1'b0;
                        rsp_rdata  <= load_data;
                        rsp_err    <= (bus.rresp != RESP_OKAY);
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                WREQ: begin
                    if (bus.awvalid && bus.awready) begin
                        bus.awvalid <= 1'b0;
                    end
                    if (bus.wvalid && bus.wready) begin
                        bus.wvalid <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        bus.bready <= 1'b1;
                        state      <= WRESP;
                    end
                end
                WRESP: begin
                    if (bus.bvalid) begin
                        bus.bready <= 1'b0;
                        rsp_err    <= (bus.bresp != RESP_OKAY);
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    rsp_err <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060180_mem_bridge.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060180_mem_bridge
//   Directed bench for the memory bridge. Inputs are driven and outputs are
//   sampled on the falling clock edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_ysyx_23060180_mem_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    int errors = 0;
    int checks = 0;

    ysyx_23060180_mem_bridge_if bus_if ();

    ysyx_23060180_mem_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wen, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_wen   = wen;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput({tag, ".arvalid"}, bus_if.arvalid, 0);
        checkOutput({tag, ".awvalid"}, bus_if.awvalid, 0);
        checkOutput({tag, ".wvalid"},  bus_if.wvalid,  0);
        checkOutput({tag, ".rready"},  bus_if.rready,  0);
        checkOutput({tag, ".bready"},  bus_if.bready,  0);
    endtask

    // Zero-wait load: arready in cycle 1, rvalid in cycle 2, response in cycle 3
    task automatic doLoad(input string tag, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] rd,
                          input logic [1:0] rr, input logic [31:0] expAddr,
                          input logic [31:0] expData, input logic expErr);
        checkOutput({tag, ".ready0"}, req_ready, 1);
        applyStimulus(1'b0, size, addr, 32'h0);
        step();
        checkOutput({tag, ".arvalid1"}, bus_if.arvalid, 1);
        checkOutput({tag, ".araddr"}, bus_if.araddr, expAddr);
        checkOutput({tag, ".rready1"}, bus_if.rready, 0);
        req_valid = 1'b0;
        bus_if.arready = 1'b1;
        step();
        checkOutput({tag, ".arvalid2"}, bus_if.arvalid, 0);
        checkOutput({tag, ".rready2"}, bus_if.rready, 1);
        bus_if.arready = 1'b0;
        bus_if.rvalid  = 1'b1;
        bus_if.rdata   = rd;
        bus_if.rresp   = rr;
        step();
        checkOutput({tag, ".rsp_valid3"}, rsp_valid, 1);
        checkOutput({tag, ".rsp_rdata"}, rsp_rdata, expData);
        checkOutput({tag, ".rsp_err"}, rsp_err, expErr);
        checkOutput({tag, ".rready3"}, bus_if.rready, 0);
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = 32'h0;
        bus_if.rresp  = 2'd0;
        step();
        checkOutput({tag, ".rsp_valid4"}, rsp_valid, 0);
        checkOutput({tag, ".ready4"}, req_ready, 1);
    endtask

    // Store with aw/w accepted together in cycle 1, then stall cycles before bvalid
    task automatic doStore(input string tag, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wd,
                           input logic [1:0] br, input int stall,
                           input logic [31:0] expAddr, input logic [31:0] expWdata,
                           input logic [3:0] expStrb, input logic expErr);
        applyStimulus(1'b1, size, addr, wd);
        step();
        checkOutput({tag, ".awvalid1"}, bus_if.awvalid, 1);
        checkOutput({tag, ".wvalid1"}, bus_if.wvalid, 1);
        checkOutput({tag, ".awaddr"}, bus_if.awaddr, expAddr);
        checkOutput({tag, ".wdata"}, bus_if.wdata, expWdata);
        checkOutput({tag, ".wstrb"}, {28'h0, bus_if.wstrb}, {28'h0, expStrb});
        req_valid = 1'b0;
        bus_if.awready = 1'b1;
        bus_if.wready  = 1'b1;
        step();
        checkOutput({tag, ".awvalid2"}, bus_if.awvalid, 0);
        checkOutput({tag, ".wvalid2"}, bus_if.wvalid, 0);
        bus_if.awready = 1'b0;
        bus_if.wready  = 1'b0;
        for (int i = 0; i < stall; i++) begin
            checkOutput({tag, ".bready_stall"}, bus_if.bready, 1);
            checkOutput({tag, ".rsp_valid_stall"}, rsp_valid, 0);
            step();
        end
        checkOutput({tag, ".bready"}, bus_if.bready, 1);
        bus_if.bvalid = 1'b1;
        bus_if.bresp  = br;
        step();
        checkOutput({tag, ".rsp_valid"}, rsp_valid, 1);
        checkOutput({tag, ".rsp_err"}, rsp_err, expErr);
        checkOutput({tag, ".rsp_rdata"}, rsp_rdata, 0);
        checkOutput({tag, ".bready_after"}, bus_if.bready, 0);
        bus_if.bvalid = 1'b0;
        bus_if.bresp  = 2'd0;
        step();
        checkOutput({tag, ".rsp_valid_end"}, rsp_valid, 0);
        checkOutput({tag, ".ready_end"}, req_ready, 1);
    endtask

    // Misaligned: error response in cycle 1, no bus activity, ready in cycle 2
    task automatic doMisaligned(input string tag, input logic wen,
                                input logic [1:0] size, input logic [31:0] addr);
        applyStimulus(wen, size, addr, 32'hCAFE_F00D);
        step();
        checkOutput({tag, ".rsp_valid"}, rsp_valid, 1);
        checkOutput({tag, ".rsp_err"}, rsp_err, 1);
        checkOutput({tag, ".rsp_rdata"}, rsp_rdata, 0);
        checkOutput({tag, ".ready1"}, req_ready, 0);
        checkIdleBus({tag, ".c1"});
        req_valid = 1'b0;
        step();
        checkOutput({tag, ".ready2"}, req_ready, 1);
        checkOutput({tag, ".rsp_valid2"}, rsp_valid, 0);
        checkIdleBus({tag, ".c2"});
    endtask

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_wen        = 1'b0;
        req_size       = 2'd0;
        req_addr       = 32'h0;
        req_wdata      = 32'h0;
        bus_if.arready = 1'b0;
        bus_if.rdata   = 32'h0;
        bus_if.rresp   = 2'd0;
        bus_if.rvalid  = 1'b0;
        bus_if.awready = 1'b0;
        bus_if.wready  = 1'b0;
        bus_if.bresp   = 2'd0;
        bus_if.bvalid  = 1'b0;

        step();
        step();
        checkOutput("reset.req_ready", req_ready, 0);
        checkOutput("reset.rsp_valid", rsp_valid, 0);
        checkOutput("reset.rsp_err", rsp_err, 0);
        checkOutput("reset.rsp_rdata", rsp_rdata, 0);
        checkOutput("reset.araddr", bus_if.araddr, 0);
        checkOutput("reset.awaddr", bus_if.awaddr, 0);
        checkOutput("reset.wdata", bus_if.wdata, 0);
        checkIdleBus("reset");
        rst = 1'b0;
        step();

        doLoad("ld_word", 32'h8000_0000, 2'd2, 32'hDEAD_BEEF, 2'd0,
               32'h8000_0000, 32'hDEAD_BEEF, 1'b0);
        doLoad("ld_byte3", 32'h8000_0003, 2'd0, 32'hAABB_CCDD, 2'd0,
               32'h8000_0000, 32'h0000_00AA, 1'b0);
        doLoad("ld_half2", 32'h8000_0002, 2'd1, 32'hAABB_CCDD, 2'd0,
               32'h8000_0000, 32'h0000_AABB, 1'b0);
        doLoad("ld_byte1_slverr", 32'h8000_0105, 2'd0, 32'h1122_3344, 2'd2,
               32'h8000_0104, 32'h0000_0033, 1'b1);

        // Half store: awready two cycles ahead of wready
        applyStimulus(1'b1, 2'd1, 32'h8000_0002, 32'h0000_1234);
        step();
        checkOutput("st_half.awvalid1", bus_if.awvalid, 1);
        checkOutput("st_half.wvalid1", bus_if.wvalid, 1);
        checkOutput("st_half.awaddr", bus_if.awaddr, 32'h8000_0000);
        checkOutput("st_half.wdata", bus_if.wdata, 32'h1234_0000);
        checkOutput("st_half.wstrb", {28'h0, bus_if.wstrb}, 32'h0000_000C);
        req_valid = 1'b0;
        bus_if.awready = 1'b1;
        step();
        checkOutput("st_half.awvalid2", bus_if.awvalid, 0);
        checkOutput("st_half.wvalid2", bus_if.wvalid, 1);
        checkOutput("st_half.bready2", bus_if.bready, 0);
        bus_if.awready = 1'b0;
        step();
        checkOutput("st_half.wvalid3", bus_if.wvalid, 1);
        checkOutput("st_half.wdata3", bus_if.wdata, 32'h1234_0000);
        checkOutput("st_half.wstrb3", {28'h0, bus_if.wstrb}, 32'h0000_000C);
        checkOutput("st_half.bready3", bus_if.bready, 0);
        bus_if.wready = 1'b1;
        step();
        checkOutput("st_half.wvalid4", bus_if.wvalid, 0);
        checkOutput("st_half.bready4", bus_if.bready, 1);
        bus_if.wready = 1'b0;
        bus_if.bvalid = 1'b1;
        bus_if.bresp  = 2'd0;
        step();
        checkOutput("st_half.rsp_valid", rsp_valid, 1);
        checkOutput("st_half.rsp_err", rsp_err, 0);
        checkOutput("st_half.rsp_rdata", rsp_rdata, 0);
        bus_if.bvalid = 1'b0;
        step();
        checkOutput("st_half.ready_end", req_ready, 1);

        doMisaligned("mis_word1", 1'b0, 2'd2, 32'h8000_0001);
        doMisaligned("mis_half3", 1'b1, 2'd1, 32'h8000_0003);
        doMisaligned("mis_size3", 1'b1, 2'd3, 32'h8000_0000);

        doStore("st_word_slverr", 32'h8000_0010, 2'd2, 32'h1122_3344, 2'd2, 5,
                32'h8000_0010, 32'h1122_3344, 4'b1111, 1'b1);
        doStore("st_byte1", 32'h8000_0021, 2'd0, 32'h0000_00AB, 2'd0, 0,
                32'h8000_0020, 32'h0000_AB00, 4'b0010, 1'b0);

        // Reset while waiting in RDATA with rvalid low
        applyStimulus(1'b0, 2'd2, 32'h8000_0020, 32'h0);
        step();
        checkOutput("rst_mid.arvalid", bus_if.arvalid, 1);
        req_valid = 1'b0;
        bus_if.arready = 1'b1;
        step();
        checkOutput("rst_mid.rready", bus_if.rready, 1);
        bus_if.arready = 1'b0;
        rst = 1'b1;
        step();
        checkOutput("rst_mid.rsp_valid", rsp_valid, 0);
        checkOutput("rst_mid.rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_mid.araddr", bus_if.araddr, 0);
        checkOutput("rst_mid.awaddr", bus_if.awaddr, 0);
        checkOutput("rst_mid.req_ready", req_ready, 0);
        checkIdleBus("rst_mid");
        rst = 1'b0;
        bus_if.rvalid = 1'b1;
        bus_if.rdata  = 32'h5555_5555;
        step();
        checkOutput("rst_mid.idle_ready", req_ready, 1);
        checkOutput("rst_mid.stray_rsp", rsp_valid, 0);
        checkOutput("rst_mid.stray_rready", bus_if.rready, 0);
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = 32'h0;
        step();
        checkOutput("rst_mid.stray_rsp2", rsp_valid, 0);
        doLoad("ld_after_rst", 32'h8000_0004, 2'd2, 32'h1234_5678, 2'd0,
               32'h8000_0004, 32'h1234_5678, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060180_mem_bridge.md
# ysyx_23060180_mem_bridge

Load/store bus bridge directly downstream of the multicycle RV32 core's memory port. It accepts one core memory request at a time over a valid/ready handshake and converts it to an AXI4-Lite-subset master transaction. It aligns addresses to words, builds byte strobes, shifts write data into lane position, and realigns read data to bit 0 so the core performs sign or zero extension unchanged. Misaligned accesses and bus error responses are returned to the core as `rsp_err`.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Fixed at 32; other values are unsupported.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: bridge can accept a request.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_err` out 1: error flag, qualified by `rsp_valid`.
- `rsp_rdata` out 32: load data right-justified, upper bits zero.
- `araddr` out 32; `arvalid` out 1; `arready` in 1.
- `rdata` in 32; `rresp` in 2; `rvalid` in 1; `rready` out 1.
- `awaddr` out 32; `awvalid` out 1; `awready` in 1.
- `wdata` out 32; `wstrb` out 4; `wvalid` out 1; `wready` in 1.
- `bresp` in 2; `bvalid` in 1; `bready` out 1.

## Operation
- **FSM states:** IDLE, RADDR, RDATA, WREQ, WRESP, RESP.
- **IDLE**
  - `req_ready`=1. A handshake latches addr, size, wen and wdata.
  - Misaligned requests go to RESP with error set and issue no bus transaction. Misaligned means half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 3.
  - Aligned loads go to RADDR. Aligned stores go to WREQ.
- **RADDR:** `arvalid`=1 and `araddr`={addr[31:2],2'b00}. On `arready`, go to RDATA.
- **RDATA:**
  - `rready`=1. On `rvalid`, capture `rdata`>>(8·addr[1:0]) masked to the access size, set error = (`rresp`≠0), then go to RESP.
- **WREQ:**
  - `awvalid` and `wvalid` are asserted on entry. Each drops independently on its own handshake; the two may complete in either order or in the same cycle.
  - `wdata` = `req_wdata`<<(8·addr[1:0]). Base mask is 0001 (byte), 0011 (half) or 1111 (word); `wstrb` = base mask << addr[1:0].
  - When both handshakes are done, go to WRESP.
- **WRESP:** `bready`=1. On `bvalid`, set error = (`bresp`≠0) and go to RESP.
- **RESP:** `rsp_valid`=1 for exactly one cycle, then return to IDLE.
  - `rsp_rdata` holds the captured value; it is 0 for stores and for misaligned requests.
- **Reset:**
  - Outputs: all valid, ready and response outputs are 0; `req_ready`=0 during the reset cycle; address and data outputs are 0.
  - FSM returns to IDLE.
  - Reset mid-transaction abandons the transaction. The slave is reset on the same `rst`.

## Timing
- All outputs are driven from registers or decoded from the registered state; there are no combinational paths from input to output except `req_ready`=(state==IDLE).
- Minimum load latency, with acceptance at cycle 0:
  - cycle 1: `arvalid`.
  - cycle 2: `rready`, when `arready` arrived in cycle 1.
  - cycle 3: `rsp_valid`, when `rvalid` arrived in cycle 2.
- Minimum store latency: same schedule, with aw/w in cycle 1, `bready` in cycle 2 and `rsp_valid` in cycle 3.
- Misaligned request: `rsp_valid`+`rsp_err` in cycle 1; no bus valid is ever asserted.
- Next acceptance is possible in the cycle after `rsp_valid`. Throughput is at most one request per 4 cycles.
- Bus valids stay high until their handshake and never drop early. Address, data and strobe are stable while the corresponding valid is high.
- Bus responses arriving outside the matching state are ignored; `rready`/`bready` are 0 outside them.

## Structure
- Shared package `ysyx_23060180_mem_pkg` holds:
  - the size encoding constants (`SIZE_B`/`SIZE_H`/`SIZE_W`);
  - the AXI resp codes (`RESP_OKAY`=0, `RESP_SLVERR`=2);
  - the bridge state enum.
- One combinational sub-module, `ysyx_23060180_mem_align`, computes the misalign flag, `wstrb`, the shifted `wdata` and the realigned/masked read data from addr[1:0] and size. The core may reuse it later.

## Test plan
- Word load at 0x80000000, slave returns 0xDEADBEEF with zero wait: `araddr`=0x80000000 in cycle 1; `rsp_valid` in cycle 3 with `rsp_rdata`=0xDEADBEEF and `rsp_err`=0.
- Byte load at 0x80000003, `rdata`=0xAABBCCDD: `araddr`=0x80000000; `rsp_rdata`=0x000000AA.
- Half store at 0x80000002, `req_wdata`=0x00001234:
  - `awaddr`=0x80000000, `wdata`=0x12340000, `wstrb`=4'b1100.
  - `awready` arrives 2 cycles before `wready`: `awvalid` drops first, `wvalid` is held, and `bready` rises only after both handshakes.
- Word load at 0x80000001: `rsp_valid`=`rsp_err`=1 in cycle 1; `arvalid` is never asserted; `req_ready` is high again in cycle 2.
- Store with `bresp`=2 after 5 stall cycles: `rsp_err`=1 with `rsp_valid` the cycle after `bvalid`.
- `rst` asserted while in RDATA with `rvalid` low:
  - next cycle, all outputs are 0 and the FSM is in IDLE.
  - a later `rvalid` pulse causes no `rsp_valid`.
  - after `rst` drops, a fresh word load completes normally.
